bcd_time_keeper: RTL

- Time-of-day core between the 1 Hz divider / key edge detectors (upstream) and the LCD controller (downstream).
- Holds HH:MM:SS as six BCD digits and advances on the 1 Hz tick.
- Accepts per-field set keys with press-to-step and hold-to-auto-repeat.
- Emits a one-cycle change strobe so the LCD controller rewrites the time line.

---
 rtl/bcd_time_keeper.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/bcd_time_keeper.sv
// bcd_time_keeper: HH:MM:SS time-of-day core with six BCD digits.
// The 1 Hz tick advances the time with full carry. Per-field set keys step
// a single field with local wrap and no carry: one step on press, one more
// after HOLD_CYCLES of holding, then one every REPEAT_CYCLES until release.
// The change output pulses for exactly the cycles in which the digits change.
module bcd_time_keeper #(
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       one_sec,
    input  logic       inc_sec_p,
    input  logic       inc_min_p,
    input  logic       inc_hr_p,
    input  logic       inc_sec_r,
    input  logic       inc_min_r,
    input  logic       inc_hr_r,
    output logic [3:0] sec_l,
    output logic [3:0] sec_h,
    output logic [3:0] min_l,
    output logic [3:0] min_h,
    output logic [3:0] hr_l,
    output logic [3:0] hr_h,
    output logic       change,
    output logic [1:0] state
);

    typedef enum logic [1:0] {RUN = 2'd0, HOLD = 2'd1, REPEAT = 2'd2} state_t;
    typedef enum logic [1:0] {FLD_NONE = 2'd0, FLD_SEC = 2'd1, FLD_MIN = 2'd2, FLD_HR = 2'd3} field_t;

    localparam int CNT_W = 25;
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    // Two-digit BCD increment over 00..59; result is {carry, tens, units}.
    function automatic logic [8:0] inc_bcd59(input logic [7:0] v);
        if (v[3:0] != 4'd9)
            return {1'b0, v[7:4], v[3:0] + 4'd1};
        else if (v[7:4] != 4'd5)
            return {1'b0, v[7:4] + 4'd1, 4'd0};
        else
            return {1'b1, 8'h00};
    endfunction

    // Two-digit BCD increment over 00..23 (wraps 23 -> 00).
    function automatic logic [7:0] inc_bcd23(input logic [7:0] v);
        if (v == 8'h23)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    state_t           state_q, state_d;
    field_t           fld_q, fld_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       sec_q, sec_d, min_q, min_d, hr_q, hr_d;
    logic             change_q, change_d;

    field_t     press_fld;
    logic       rel_hit;
    logic       step_en;
    logic       tick_en;
    field_t     step_fld;
    logic [8:0] sec_inc, min_inc;
    logic [7:0] hr_inc;

    // Next-state: key FSM, hold/repeat counter, and digit update.
    always_comb begin
        state_d  = state_q;
        fld_d    = fld_q;
        cnt_d    = cnt_q;
        sec_d    = sec_q;
        min_d    = min_q;
        hr_d     = hr_q;
        change_d = 1'b0;
        step_en  = 1'b0;
        tick_en  = 1'b0;
        step_fld = fld_q;

        // Simultaneous presses: hours win over minutes over seconds.
        if (inc_hr_p)       press_fld = FLD_HR;
        else if (inc_min_p) press_fld = FLD_MIN;
        else if (inc_sec_p) press_fld = FLD_SEC;
        else                press_fld = FLD_NONE;

        rel_hit = (fld_q == FLD_SEC && inc_sec_r) ||
                  (fld_q == FLD_MIN && inc_min_r) ||
                  (fld_q == FLD_HR  && inc_hr_r);

        case (state_q)
            RUN: begin
                if (press_fld != FLD_NONE) begin
                    step_en  = 1'b1;
                    step_fld = press_fld;
                    fld_d    = press_fld;
                    cnt_d    = '0;
                    state_d  = HOLD;
                end else if (one_sec) begin
                    tick_en = 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    step_en = 1'b1;
                    cnt_d   = '0;
                    state_d = REPEAT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                // A due step still lands in the release cycle.
                if (rel_hit) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            REPEAT: begin
                if (cnt_q == REPEAT_LAST) begin
                    step_en = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (rel_hit) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = RUN;
                fld_d   = FLD_NONE;
                cnt_d   = '0;
            end
        endcase

        sec_inc = inc_bcd59(sec_q);
        min_inc = inc_bcd59(min_q);
        hr_inc  = inc_bcd23(hr_q);

        // Tick carries across fields; a key step never carries.
        if (tick_en) begin
            change_d = 1'b1;
            sec_d    = sec_inc[7:0];
            if (sec_inc[8]) begin
                min_d = min_inc[7:0];
                if (min_inc[8])
                    hr_d = hr_inc;
            end
        end

        if (step_en) begin
            case (step_fld)
                FLD_SEC: begin sec_d = sec_inc[7:0]; change_d = 1'b1; end
                FLD_MIN: begin min_d = min_inc[7:0]; change_d = 1'b1; end
                FLD_HR:  begin hr_d  = hr_inc;       change_d = 1'b1; end
                default: ;
            endcase
        end
    end

    // State and digit registers; reset overrides every other input.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q  <= RUN;
            fld_q    <= FLD_NONE;
            cnt_q    <= '0;
            sec_q    <= 8'h00;
            min_q    <= 8'h00;
            hr_q     <= 8'h00;
            change_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            fld_q    <= fld_d;
            cnt_q    <= cnt_d;
            sec_q    <= sec_d;
            min_q    <= min_d;
            hr_q     <= hr_d;
            change_q <= change_d;
        end
    end

    assign sec_l  = sec_q[3:0];
    assign sec_h  = sec_q[7:4];
    assign min_l  = min_q[3:0];
    assign min_h  = min_q[7:4];
    assign hr_l   = hr_q[3:0];
    assign hr_h   = hr_q[7:4];
    assign change = change_q;
    assign state  = state_q;

endmodule
